// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock on a start/done handshake.
// Quotient, remainder and divide-by-zero flag are registered and held until the next done.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [2*WIDTH:0] nxt;

  // One restoring step on {partial remainder, dividend shift}. The trial
  // subtraction is widened by one bit so its sign lands in a dedicated MSB.
  function automatic logic [2*WIDTH:0] div_step(
    input logic [WIDTH:0]   pr,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] dv
  );
    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] trial;
    sh    = {pr, d[WIDTH-1]};
    trial = sh - {2'b00, dv};
    if (!trial[WIDTH+1])
      return {trial[WIDTH:0], d[WIDTH-2:0], 1'b1};
    else
      return {sh[WIDTH:0], d[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    nxt = div_step(prem, dq, dvs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prem        <= '0;
      dq          <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              dq    <= dividend;
              dvs   <= divisor;
              prem  <= '0;
              cnt   <= CW'(WIDTH);
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem <= nxt[2*WIDTH:WIDTH];
          dq   <= nxt[WIDTH-1:0];
          cnt  <= cnt - CW'(1);
          // Final step: publish the freshly computed bits directly.
          if (cnt == CW'(1)) begin
            quotient    <= nxt[WIDTH-1:0];
            remainder   <= nxt[2*WIDTH-1:WIDTH];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-level reference for WIDTH=8, directed
// vectors with literal results, and a randomised invariant sweep at WIDTH=8 and 16.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8, busy8, done8, z8;
  logic [7:0]  a8, b8, q8, r8;
  logic        start16, busy16, done16, z16;
  logic [15:0] a16, b16, q16, r16;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  seq_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(a16), .divisor(b16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference for the 8-bit unit: a countdown of remaining busy cycles plus
  // the arithmetic result, which becomes visible when the done cycle begins.
  int         m_cnt = 0;
  logic [7:0] m_q = 8'd0, m_r = 8'd0, p_q = 8'd0, p_r = 8'd0;
  logic       m_z = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_q   <= 8'd0;
      m_r   <= 8'd0;
      m_z   <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start8) begin
        if (b8 == 8'd0) begin
          m_cnt <= 1;
          m_q   <= 8'hff;
          m_r   <= a8;
          m_z   <= 1'b1;
        end else begin
          m_cnt <= 9;
          p_q   <= a8 / b8;
          p_r   <= a8 % b8;
        end
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_q <= p_q;
        m_r <= p_r;
        m_z <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy8", 32'(busy8), 32'(m_cnt > 0));
    chk("cyc_done8", 32'(done8), 32'(m_cnt == 1));
    chk("cyc_quot8", 32'(q8), 32'(m_q));
    chk("cyc_rem8",  32'(r8), 32'(m_r));
    chk("cyc_dbz8",  32'(z8), 32'(m_z));
  end

  // Called at a negedge while idle; returns at the negedge of the first idle cycle.
  task automatic do8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int n;
    int lat;
    lat = (b == 8'd0) ? 1 : 9;
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    chk("busy8_cycle1", 32'(busy8), 32'd1);
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency8", 32'(n), 32'(lat));
    chk("quot8", 32'(q8), 32'(eq));
    chk("rem8",  32'(r8), 32'(er));
    chk("dbz8",  32'(z8), 32'(ez));
    @(negedge clk);
    chk("idle8", 32'(busy8), 32'd0);
  endtask

  task automatic do16(input logic [15:0] a, input logic [15:0] b);
    int n;
    int lat;
    lat = (b == 16'd0) ? 1 : 17;
    start16 = 1'b1; a16 = a; b16 = b;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    n = 1;
    while (!done16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency16", 32'(n), 32'(lat));
    if (b == 16'd0) begin
      chk("dbz16_flag", 32'(z16), 32'd1);
      chk("dbz16_quot", 32'(q16), 32'hffff);
      chk("dbz16_rem",  32'(r16), 32'(a));
    end else begin
      chk("inv16", 32'(q16) * 32'(b) + 32'(r16), 32'(a));
      chk("rem16_lt", 32'(r16 < b), 32'd1);
      chk("dbz16_clr", 32'(z16), 32'd0);
    end
    @(negedge clk);
    chk("idle16", 32'(busy16), 32'd0);
  endtask

  initial begin
    int n;
    start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start16 = 1'b0; a16 = 16'd0; b16 = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_q8", 32'(q8), 32'd0);
    chk("rst_r8", 32'(r8), 32'd0);
    chk("rst_z8", 32'(z8), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_q16", 32'(q16), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do8(8'd100, 8'd7,   8'd14,  8'd2,  1'b0);
    do8(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
    do8(8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
    do8(8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
    do8(8'd0,   8'd3,   8'd0,   8'd0,  1'b0);
    do8(8'd77,  8'd0,   8'd255, 8'd77, 1'b1);
    do8(8'd10,  8'd3,   8'd3,   8'd1,  1'b0);

    // Start held high with other operands while busy must be ignored.
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd6;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9;
    n = 1;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 5) begin a8 = 8'd3; b8 = 8'd1; end
    end
    start8 = 1'b0;
    chk("rej_latency", 32'(n), 32'd9);
    chk("rej_quot", 32'(q8), 32'd33);
    chk("rej_rem",  32'(r8), 32'd2);
    @(negedge clk);

    // Asynchronous reset during cycle 4 of a division.
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    chk("mid_rst_q", 32'(q8), 32'd0);
    chk("mid_rst_r", 32'(r8), 32'd0);
    chk("mid_rst_z", 32'(z8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done8), 32'd0);
    end
    do8(8'd50, 8'd8, 8'd6, 8'd2, 1'b0);

    fork
      begin : sweep8
        logic [7:0] ra, rb;
        for (int i = 0; i < 1000; i++) begin
          ra = 8'($urandom);
          rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
          if (rb == 8'd0) do8(ra, rb, 8'hff, ra, 1'b1);
          else            do8(ra, rb, ra / rb, ra % rb, 1'b0);
        end
      end
      begin : sweep16
        logic [15:0] sa, sb;
        for (int i = 0; i < 1000; i++) begin
          sa = 16'($urandom);
          case ($urandom_range(0, 15))
            0:       sb = 16'd0;
            1, 2:    sb = 16'($urandom_range(1, 15));
            default: sb = 16'($urandom);
          endcase
          do16(sa, sb);
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
